shift_add_multiplier: RTL and testbench

- Iterative unsigned shift-and-add multiplier. It is the stage directly upstream of the 8-bit ripple adder in the multiplier-and-accumulator datapath.
- Takes two WIDTH-bit operands and produces a 2*WIDTH-bit product, one partial product per clock.
- When the product is ready, it raises a one-cycle done pulse and a start2 strobe. The downstream adder consumes the product on that strobe, alongside the running accumulation.

---
 rtl/shift_add_multiplier.sv | 102 ++++++++++
 tb/tb_shift_add_multiplier.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one partial product per clock,
// WIDTH-bit operands to a 2*WIDTH-bit product, with done/start2 completion strobes.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 start2
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [PW-1:0]      acc;
    logic [CNT_W-1:0]   count;
    logic [PW-1:0]      acc_sum;
    logic               last_iter;

    // Partial-product accumulation for the current iteration
    assign acc_sum   = acc + (mplier[0] ? mcand : PW'(0));
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath; product is loaded only on the final iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= PW'(a);
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (last_iter) begin
                        product <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags registered from the next state so they track the FSM exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            start2 <= 1'b0;
        end else begin
            busy   <= (next_state != IDLE);
            done   <= (next_state == DONE);
            start2 <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios, exhaustive sweep
// and random traffic against a cycle-count reference model.
module tb_shift_add_multiplier;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PW    = 2 * WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [PW-1:0]     product;
    logic              busy;
    logic              done;
    logic              start2;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int cyc = 0;

    // Reference model: remaining cycles of the current operation and its result
    int            rem = 0;
    int            pend = 0;
    logic [PW-1:0] exp_prod = '0;
    bit            mvalid = 1'b0;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done),
        .start2  (start2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // An accepted op keeps the block busy WIDTH+1 cycles; the last of them is the done cycle
    always @(posedge clk) begin
        if (rst) begin
            rem      = 0;
            exp_prod = '0;
            mvalid   = 1'b1;
        end else if (rem == 0) begin
            if (start) begin
                rem  = WIDTH + 1;
                pend = int'(a) * int'(b);
            end
        end else begin
            rem--;
            if (rem == 1) exp_prod = PW'(pend);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mvalid) begin
            check("product", 32'(product), 32'(exp_prod));
            check("busy",    32'(busy),    32'(rem != 0));
            check("done",    32'(done),    32'(rem == 1));
            check("start2",  32'(start2),  32'(rem == 1));
        end
        if (done) done_cnt++;
    end

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [PW-1:0] exp, input string tag);
        int k;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check({tag, "_lat"}, 32'(k + 1), 32'(WIDTH + 1));
        check({tag, "_prod"}, 32'(product), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        int k;
        int d0;
        int t0;
        int t1;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_prod", 32'(product), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);

        run_op(4'hF, 4'hF, 8'hE1, "ff");
        run_op(4'h9, 4'h6, 8'h36, "96");
        run_op(4'h0, 4'hB, 8'h00, "0b");

        // Starts during RUN and during DONE are ignored
        d0 = done_cnt;
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd7; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_prod", 32'(product), 32'h0F);
        repeat (8) @(negedge clk);
        check("ign_pulses", 32'(done_cnt - d0), 32'd1);
        check("ign_hold", 32'(product), 32'h0F);

        // Start held high: accepted every WIDTH+2 cycles
        a = 4'd2; b = 4'd8; start = 1'b1;
        @(negedge clk);
        wait_done(k);
        t0 = cyc;
        check("held_prod", 32'(product), 32'h10);
        @(negedge clk);
        wait_done(k);
        t1 = cyc;
        check("held_gap", 32'(t1 - t0), 32'(WIDTH + 2));
        start = 1'b0;
        repeat (10) @(negedge clk);

        // Reset on the third RUN cycle aborts without a done pulse
        d0 = done_cnt;
        a = 4'hF; b = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_prod", 32'(product), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (8) @(negedge clk);
        check("abort_pulses", 32'(done_cnt - d0), 32'd0);
        run_op(4'h1, 4'h1, 8'h01, "11");

        // rst and start on the same edge: rst wins
        rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'h0);
        @(negedge clk);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_op(WIDTH'(ia), WIDTH'(ib), PW'(ia * ib), "sweep");
            end
        end

        // Random traffic with occasional resets, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            rst   = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
